// File: rtl/alu_regfile.sv
// alu_regfile: operand-supply / result-return end of the integer ALU datapath.
//
// Holds the 32 x XLEN integer register file plus a per-register pending
// scoreboard. Decoded register indices arrive on an issue handshake; the
// operands are read, registered, and presented to the ALU on an op handshake.
// ALU results come back on an always-accepted writeback port.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   issue_valid / issue_ready  issue handshake (ready is combinational)
//   issue_rs1/rs2/rd/rd_we     decoded source/destination indices
//   op_valid / op_ready        operand handshake towards the ALU
//   op_rs1/op_rs2              registered operand values
//   op_rd/op_rd_we             destination passed through for writeback
//   wb_valid/wb_rd/wb_data     ALU result writeback (no backpressure)
//
// Build option:
//   ALU_REGFILE_BYPASS_EN  forward same-cycle writeback data into the operand
//                          register and treat that register as no longer
//                          pending for the hazard check.
module alu_regfile #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            issue_valid,
  output logic            issue_ready,
  input  logic [4:0]      issue_rs1,
  input  logic [4:0]      issue_rs2,
  input  logic [4:0]      issue_rd,
  input  logic            issue_rd_we,
  output logic            op_valid,
  input  logic            op_ready,
  output logic [XLEN-1:0] op_rs1,
  output logic [XLEN-1:0] op_rs2,
  output logic [4:0]      op_rd,
  output logic            op_rd_we,
  input  logic            wb_valid,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data
);

  logic [XLEN-1:0] rf [NREG];
  logic [NREG-1:0] pend;
  logic [NREG-1:0] wb_clr;
  logic [NREG-1:0] iss_set;
  logic [NREG-1:0] pend_eff;
  logic            hazard;
  logic            accept;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;

  logic            vld_p0;
  logic [XLEN-1:0] rs1_p0;
  logic [XLEN-1:0] rs2_p0;
  logic [4:0]      rd_p0;
  logic            rd_we_p0;

  always_comb begin
    wb_clr = '0;
    if (wb_valid && wb_rd != 5'd0) wb_clr[wb_rd] = 1'b1;

`ifdef ALU_REGFILE_BYPASS_EN
    // A register being written back this cycle can be forwarded, so it no
    // longer blocks the issue.
    pend_eff = pend & ~wb_clr;
`else
    pend_eff = pend;
`endif

    hazard = (issue_rs1 != 5'd0 && pend_eff[issue_rs1]) ||
             (issue_rs2 != 5'd0 && pend_eff[issue_rs2]) ||
             (issue_rd_we && issue_rd != 5'd0 && pend_eff[issue_rd]);

    issue_ready = !hazard && (!vld_p0 || op_ready);
    accept      = issue_valid && issue_ready;

    iss_set = '0;
    if (accept && issue_rd_we && issue_rd != 5'd0) iss_set[issue_rd] = 1'b1;

    rs1_val = (issue_rs1 == 5'd0) ? '0 : rf[issue_rs1];
    rs2_val = (issue_rs2 == 5'd0) ? '0 : rf[issue_rs2];
`ifdef ALU_REGFILE_BYPASS_EN
    if (wb_valid && wb_rd != 5'd0 && wb_rd == issue_rs1) rs1_val = wb_data;
    if (wb_valid && wb_rd != 5'd0 && wb_rd == issue_rs2) rs2_val = wb_data;
`endif
  end

  // ---- stage p0: scoreboard and operand-valid control ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend   <= '0;
      vld_p0 <= 1'b0;
    end else begin
      // Issue set is OR-ed after the writeback clear so a same-register
      // set/clear collision leaves the bit pending.
      pend <= (pend & ~wb_clr) | iss_set;
      if (accept)        vld_p0 <= 1'b1;
      else if (op_ready) vld_p0 <= 1'b0;
    end
  end

  // ---- stage p0: register array and operand data ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
      rs1_p0   <= '0;
      rs2_p0   <= '0;
      rd_p0    <= '0;
      rd_we_p0 <= 1'b0;
    end else begin
      if (wb_valid && wb_rd != 5'd0) rf[wb_rd] <= wb_data;
      if (accept) begin
        rs1_p0   <= rs1_val;
        rs2_p0   <= rs2_val;
        rd_p0    <= issue_rd;
        rd_we_p0 <= issue_rd_we;
      end
    end
  end

  assign op_valid = vld_p0;
  assign op_rs1   = rs1_p0;
  assign op_rs2   = rs2_p0;
  assign op_rd    = rd_p0;
  assign op_rd_we = rd_we_p0;

endmodule

// File: tb/tb_alu_regfile.sv
// Scoreboard bench for alu_regfile: directed issue/writeback vectors push
// expected operand packets into a queue; a monitor pops and compares each
// time the ALU side consumes an operation.
module tb_alu_regfile;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        issue_valid;
  logic        issue_ready;
  logic [4:0]  issue_rs1;
  logic [4:0]  issue_rs2;
  logic [4:0]  issue_rd;
  logic        issue_rd_we;
  logic        op_valid;
  logic        op_ready;
  logic [31:0] op_rs1;
  logic [31:0] op_rs2;
  logic [4:0]  op_rd;
  logic        op_rd_we;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  alu_regfile #(.XLEN(32), .NREG(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .issue_valid (issue_valid),
    .issue_ready (issue_ready),
    .issue_rs1   (issue_rs1),
    .issue_rs2   (issue_rs2),
    .issue_rd    (issue_rd),
    .issue_rd_we (issue_rd_we),
    .op_valid    (op_valid),
    .op_ready    (op_ready),
    .op_rs1      (op_rs1),
    .op_rs2      (op_rs2),
    .op_rd       (op_rd),
    .op_rd_we    (op_rd_we),
    .wb_valid    (wb_valid),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] r1;
    logic [31:0] r2;
    logic [4:0]  rd;
    logic        we;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", nm, act, exp);
    end
  endtask

  // Monitor: an op is consumed at the next rising edge when valid and ready
  // are both high mid-cycle.
  always @(negedge clk) begin
    if (rst_n && op_valid && op_ready) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_op: got=op rd=%0d want=no op", op_rd);
      end else begin
        mon_e = q.pop_front();
        chk("op_rs1",   op_rs1,         mon_e.r1);
        chk("op_rs2",   op_rs2,         mon_e.r2);
        chk("op_rd",    32'(op_rd),     32'(mon_e.rd));
        chk("op_rd_we", 32'(op_rd_we),  32'(mon_e.we));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one op that must be accepted in the presented cycle.
  task automatic do_issue(input logic [4:0] a, input logic [4:0] b, input logic [4:0] d,
                          input logic w, input logic [31:0] e1, input logic [31:0] e2,
                          input bit push, input string nm);
    issue_valid = 1'b1;
    issue_rs1   = a;
    issue_rs2   = b;
    issue_rd    = d;
    issue_rd_we = w;
    #1;
    chk({nm, "_ready"}, 32'(issue_ready), 32'd1);
    if (issue_ready && push) q.push_back({e1, e2, d, w});
    @(posedge clk);
    #1;
    issue_valid = 1'b0;
  endtask

  task automatic do_wb(input logic [4:0] d, input logic [31:0] v);
    wb_valid = 1'b1;
    wb_rd    = d;
    wb_data  = v;
    @(posedge clk);
    #1;
    wb_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; issue_valid = 1'b0; issue_rs1 = '0; issue_rs2 = '0;
    issue_rd = '0; issue_rd_we = 1'b0; op_ready = 1'b1;
    wb_valid = 1'b0; wb_rd = '0; wb_data = '0;
    step();
    step();
    rst_n = 1'b1;
    #1;
    chk("rst_op_valid",    32'(op_valid),    32'd0);
    chk("rst_op_rs1",      op_rs1,           32'd0);
    chk("rst_op_rs2",      op_rs2,           32'd0);
    chk("rst_issue_ready", 32'(issue_ready), 32'd1);

    // Fresh registers read as zero
    do_issue(5'd5, 5'd6, 5'd0, 1'b0, 32'd0, 32'd0, 1, "t1");

    // Writeback then read through the array
    do_issue(5'd0, 5'd0, 5'd3, 1'b1, 32'd0, 32'd0, 1, "t2_set");
    do_wb(5'd3, 32'h0000_00AA);
    do_issue(5'd3, 5'd0, 5'd0, 1'b0, 32'h0000_00AA, 32'd0, 1, "t2_read");

    // RAW stall on x7
    do_issue(5'd0, 5'd0, 5'd7, 1'b1, 32'd0, 32'd0, 1, "t3_set");
    issue_valid = 1'b1; issue_rs1 = 5'd7; issue_rs2 = 5'd0;
    issue_rd = 5'd0; issue_rd_we = 1'b0;
    #1;
    chk("raw_stall1", 32'(issue_ready), 32'd0);
    step();
    chk("raw_stall2", 32'(issue_ready), 32'd0);
    wb_valid = 1'b1; wb_rd = 5'd7; wb_data = 32'h1234_5678;
    #1;
`ifdef ALU_REGFILE_BYPASS_EN
    chk("raw_wb_cycle", 32'(issue_ready), 32'd1);
    q.push_back({32'h1234_5678, 32'd0, 5'd0, 1'b0});
    step();
    wb_valid = 1'b0;
    issue_valid = 1'b0;
`else
    chk("raw_wb_cycle", 32'(issue_ready), 32'd0);
    step();
    wb_valid = 1'b0;
    #1;
    chk("raw_after_wb", 32'(issue_ready), 32'd1);
    q.push_back({32'h1234_5678, 32'd0, 5'd0, 1'b0});
    step();
    issue_valid = 1'b0;
`endif

    // x0 is never written and never pending
    do_wb(5'd0, 32'hFFFF_FFFF);
    do_issue(5'd0, 5'd0, 5'd0, 1'b1, 32'd0, 32'd0, 1, "t4_x0we");
    do_issue(5'd0, 5'd7, 5'd0, 1'b0, 32'd0, 32'h1234_5678, 1, "t4_x0rd");

    // Backpressure: op held stable, then released with no bubble
    step();
    op_ready = 1'b0;
    do_issue(5'd3, 5'd7, 5'd12, 1'b1, 32'h0000_00AA, 32'h1234_5678, 1, "t5_load");
    issue_valid = 1'b1; issue_rs1 = 5'd3; issue_rs2 = 5'd0;
    issue_rd = 5'd0; issue_rd_we = 1'b0;
    #1;
    chk("bp_ready", 32'(issue_ready), 32'd0);
    step();
    step();
    chk("bp_valid",   32'(op_valid),    32'd1);
    chk("bp_rs1",     op_rs1,           32'h0000_00AA);
    chk("bp_rs2",     op_rs2,           32'h1234_5678);
    chk("bp_rd",      32'(op_rd),       32'd12);
    chk("bp_rd_we",   32'(op_rd_we),    32'd1);
    chk("bp_ready2",  32'(issue_ready), 32'd0);
    op_ready = 1'b1;
    #1;
    chk("bp_release", 32'(issue_ready), 32'd1);
    q.push_back({32'h0000_00AA, 32'd0, 5'd0, 1'b0});
    step();
    issue_valid = 1'b0;
    chk("no_bubble_valid", 32'(op_valid), 32'd1);
    chk("no_bubble_rd",    32'(op_rd),    32'd0);
    step();

    // WAW: x12 still pending
    issue_valid = 1'b1; issue_rs1 = 5'd0; issue_rs2 = 5'd0;
    issue_rd = 5'd12; issue_rd_we = 1'b1;
    #1;
    chk("waw_stall", 32'(issue_ready), 32'd0);
    issue_valid = 1'b0;
    step();

    // Reset with x9 pending and an op held
    op_ready = 1'b0;
    do_issue(5'd0, 5'd0, 5'd9, 1'b1, 32'd0, 32'd0, 0, "t7_set");
    chk("t7_held", 32'(op_valid), 32'd1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    op_ready = 1'b1;
    #1;
    chk("rst2_op_valid", 32'(op_valid), 32'd0);
    chk("rst2_op_rd",    32'(op_rd),    32'd0);
    chk("rst2_op_rd_we", 32'(op_rd_we), 32'd0);
    do_issue(5'd9, 5'd12, 5'd0, 1'b0, 32'd0, 32'd0, 1, "t7_after");
    do_issue(5'd3, 5'd0, 5'd0, 1'b0, 32'd0, 32'd0, 1, "t7_rf_clr");

    step();
    step();
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_regfile.md
# alu_regfile

Operand-supply and result-return end of the integer ALU datapath. Holds the 32 × 32-bit integer register file and a per-register scoreboard. Accepts decoded register indices on an issue handshake and presents registered rs1/rs2 operand values to the ALU function units. Retires ALU rd results through a writeback port, so the ALU units themselves stay purely combinational.

## Interface
Parameters:
- XLEN, 32, data width of registers, operands and writeback data.
- NREG, 32, number of architectural registers; fixed at 32 to match 5-bit indices.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset: synchronous, active-low.
- issue_valid  in  1  decoder presents an operation.
- issue_ready  out  1  block can accept the operation this cycle.
- issue_rs1  in  5  source register 1 index.
- issue_rs2  in  5  source register 2 index.
- issue_rd  in  5  destination register index.
- issue_rd_we  in  1  operation will write issue_rd.
- op_valid  out  1  operand register holds a valid operation.
- op_ready  in  1  ALU consumes the operation.
- op_rs1  out  XLEN  operand 1 value.
- op_rs2  out  XLEN  operand 2 value.
- op_rd  out  5  destination index passed through for writeback.
- op_rd_we  out  1  destination-write flag passed through.
- wb_valid  in  1  writeback of an ALU result this cycle.
- wb_rd  in  5  writeback register index.
- wb_data  in  XLEN  writeback value.

## Operation
- Register x0 reads as 0 and is never written. A writeback to x0 is discarded and touches no scoreboard bit.
- Scoreboard: one pending bit per register for x1..x31.
  - Set on an accepted issue with issue_rd_we=1 and issue_rd≠0.
  - Cleared on wb_valid for wb_rd.
- Hazard exists if any of these pending bits is set, excluding bits cleared by a same-cycle writeback (bypass only):
  - issue_rs1 (if ≠0)
  - issue_rs2 (if ≠0)
  - issue_rd (if issue_rd_we and ≠0; WAW)
- issue_ready = !hazard && (!op_valid || op_ready). This is a combinational function of the inputs and state.
- Accept = issue_valid && issue_ready. On accept, the operand register loads:
  - op_rs1 and op_rs2 from the array, or from wb_data when bypassed;
  - op_rd and op_rd_we from the issue inputs;
  - op_valid is set to 1.
- op_valid && op_ready with no new accept: op_valid clears to 0; the data fields hold their last value.
- op_valid && !op_ready: all op_* outputs are held stable.
- Same-cycle wb clear and issue set on one register: set wins, and the bit stays pending.
- Writeback is always accepted; there is no backpressure on wb.

## Timing
- Reset value of every output and all state is 0:
  - op_valid, op_rs1, op_rs2, op_rd, op_rd_we are 0;
  - all registers are 0;
  - the scoreboard is clear.
- issue_ready becomes valid once the reset cycle completes.
- Reset mid-operation discards the held operation and all pending bits. In-flight writebacks arriving after reset still write the array.
- Latency: an issue accepted in cycle N gives op_valid=1 in cycle N+1.
- Throughput: 1 operation/cycle while op_ready=1 and there are no hazards.
- Writeback timing: wb_data written in cycle N is readable through the array by an issue in cycle N+1.
- Dependent issue: it stalls until the writeback cycle (bypass) or the cycle after it (no bypass).

## Configuration
- ALU_REGFILE_BYPASS_EN defined:
  - A same-cycle writeback matching issue_rs1/issue_rs2 forwards wb_data into op_rs1/op_rs2.
  - That matching pending bit is treated as clear for the hazard check.
- ALU_REGFILE_BYPASS_EN undefined:
  - There is no forwarding.
  - The hazard check uses the scoreboard as registered, so a dependent issue accepts one cycle after the writeback.

## Test plan
- Reset → op_valid=0, op_rs1=op_rs2=0, issue_ready=1; issue rs1=5 rs2=6 → op_rs1=op_rs2=0 next cycle.
- Issue rd=3 we=1, then wb rd=3 data=0x0000_00AA; then issue rs1=3 rs2=0 → op_rs1=0x0000_00AA, op_rs2=0.
- RAW stall: issue rd=7 we=1, then issue rs1=7 → issue_ready=0 until wb rd=7 data=0x1234_5678.
  - Bypass: accepted in the wb cycle with op_rs1=0x1234_5678.
  - No bypass: accepted one cycle later with the same value.
- Writes to x0: wb rd=0 data=0xFFFF_FFFF, issue rd=0 we=1, then issue rs1=0 → no stall, op_rs1=0.
- Backpressure: hold op_ready=0 with op_valid=1 → op_* stable and issue_ready=0; raise op_ready → next op loaded the same cycle, no bubble.
- Reset while rd=9 is pending and op_valid=1 → after reset op_valid=0; issue rs1=9 accepted immediately.
